// File: rtl/stream_join_reg.sv
// Registered N-way stream join.
// Each input stream handshakes into its own one-entry slot. Once every slot
// holds an item, one output beat is presented that carries all slot data
// concatenated, with slot k at bits [k*DATA_WIDTH +: DATA_WIDTH].
// The join absorbs arrival skew between branches that were fed by a fork.
// Optional feature macro: STREAM_JOIN_SKEW_EN adds skew_o, which reports how
// many cycles the pending beat has spent partially filled.
module stream_join_reg #(
    parameter int N_INP      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int SKEW_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [N_INP-1:0]            valid_i,
    output logic [N_INP-1:0]            ready_o,
    input  logic [N_INP*DATA_WIDTH-1:0] data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [N_INP*DATA_WIDTH-1:0] data_o
`ifdef STREAM_JOIN_SKEW_EN
    ,
    output logic [SKEW_WIDTH-1:0]       skew_o
`endif
);

    // Parameter sanity checks: a zero-width join makes no sense.
    if (N_INP < 1) begin : g_bad_n_inp
        $fatal(1, "stream_join_reg: N_INP must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $fatal(1, "stream_join_reg: DATA_WIDTH must be >= 1");
    end
    if (SKEW_WIDTH < 1) begin : g_bad_skew_width
        $fatal(1, "stream_join_reg: SKEW_WIDTH must be >= 1");
    end

    logic [N_INP-1:0]                 full_q;
    logic [N_INP-1:0]                 full_d;
    logic [N_INP-1:0][DATA_WIDTH-1:0] data_q;
    logic [N_INP-1:0]                 inp_hs;
    logic                             oup_hs;

    // Handshake logic. A full slot only accepts a new item in the same cycle
    // it is drained by the output, so no input can deliver two items for one
    // beat. Flush suppresses every handshake and empties all slots.
    always_comb begin
        valid_o = ~flush_i & (&full_q);
        oup_hs  = valid_o & ready_i;
        ready_o = {N_INP{~flush_i}} & (~full_q | {N_INP{oup_hs}});
        inp_hs  = valid_i & ready_o;
        full_d  = inp_hs | (full_q & ~{N_INP{oup_hs}});
        if (flush_i) begin
            full_d = '0;
        end
    end

    assign data_o = data_q;

    // Slot registers: occupancy always updates, data only on input handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            for (int k = 0; k < N_INP; k++) begin
                if (inp_hs[k]) begin
                    data_q[k] <= data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

`ifdef STREAM_JOIN_SKEW_EN
    logic [SKEW_WIDTH-1:0] cnt_q;
    logic                  partial;

    assign partial = (|full_q) & ~(&full_q);
    assign skew_o  = cnt_q;

    // Skew counter: counts cycles spent partially filled, saturating, and
    // restarts whenever the pending beat leaves or is flushed.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (flush_i || oup_hs) begin
            cnt_q <= '0;
        end else if (partial && (cnt_q != {SKEW_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_join_reg.sv
// Self-checking bench for stream_join_reg with N_INP=3, DATA_WIDTH=8.
// A reference model holds one queue of accepted items per input; a beat is
// available when every queue is non-empty and carries the queue fronts.
module tb_stream_join_reg;

    localparam int N = 3;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic [N-1:0]   valid_in;
    logic [N-1:0]   ready_out;
    logic [N*W-1:0] data_in;
    logic           valid_out;
    logic           ready_in;
    logic [N*W-1:0] data_out;
`ifdef STREAM_JOIN_SKEW_EN
    logic [7:0]     skew;
`endif

    logic [W-1:0] slot_q[N][$];
    int           skew_m;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_beats  = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    stream_join_reg #(
        .N_INP      (N),
        .DATA_WIDTH (W),
        .SKEW_WIDTH (8)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .data_i  (data_in),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .data_o  (data_out)
`ifdef STREAM_JOIN_SKEW_EN
        ,
        .skew_o  (skew)
`endif
    );

    function automatic int filled();
        int c = 0;
        for (int k = 0; k < N; k++) begin
            if (slot_q[k].size() != 0) c++;
        end
        return c;
    endfunction

    task automatic checkOutput();
        logic           exp_valid;
        logic [N-1:0]   exp_ready;
        logic [N*W-1:0] exp_data;
        exp_valid = !flush && (filled() == N);
        for (int k = 0; k < N; k++) begin
            exp_ready[k] = !flush && ((slot_q[k].size() == 0) || (exp_valid && ready_in));
        end
        n_checks++;
        assert (valid_out === exp_valid) else begin
            n_fail++;
            $error("[TB] FAIL valid_o observed=%b expected=%b", valid_out, exp_valid);
        end
        n_checks++;
        assert (ready_out === exp_ready) else begin
            n_fail++;
            $error("[TB] FAIL ready_o observed=%b expected=%b", ready_out, exp_ready);
        end
        if (exp_valid) begin
            for (int k = 0; k < N; k++) exp_data[k*W +: W] = slot_q[k][0];
            n_checks++;
            assert (data_out === exp_data) else begin
                n_fail++;
                $error("[TB] FAIL data_o observed=%h expected=%h", data_out, exp_data);
            end
        end
`ifdef STREAM_JOIN_SKEW_EN
        n_checks++;
        assert (skew === skew_m[7:0]) else begin
            n_fail++;
            $error("[TB] FAIL skew_o observed=%0d expected=%0d", skew, skew_m);
        end
`endif
    endtask

    task automatic updateModel();
        int   f;
        logic ohs;
        logic rdy;
        f   = filled();
        ohs = !flush && (f == N) && ready_in;
        if (!rst_n || flush) begin
            for (int k = 0; k < N; k++) slot_q[k].delete();
            skew_m = 0;
        end else begin
            if (ohs) n_beats++;
            for (int k = 0; k < N; k++) begin
                rdy = (slot_q[k].size() == 0) || ohs;
                if (ohs) void'(slot_q[k].pop_front());
                if (valid_in[k] && rdy) slot_q[k].push_back(data_in[k*W +: W]);
            end
            if (ohs) skew_m = 0;
            else if (f > 0 && f < N) skew_m = (skew_m == 255) ? 255 : skew_m + 1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic [N-1:0] v,
                                 input logic [N*W-1:0] d, input logic rd);
        rst_n    = r;
        flush    = f;
        valid_in = v;
        data_in  = d;
        ready_in = rd;
        #1;
        checkOutput();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    initial begin
        skew_m   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_in = '0;
        data_in  = '0;
        ready_in = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset then idle");
        applyStimulus(1'b0, 1'b0, 3'b000, 24'h0, 1'b0);
        n_checks++;
        assert (data_out === 24'h0) else begin
            n_fail++;
            $error("[TB] FAIL reset_data observed=%h expected=%h", data_out, 24'h0);
        end
        applyStimulus(1'b1, 1'b0, 3'b000, 24'h0, 1'b0);

        $display("[TB] simultaneous arrival");
        applyStimulus(1'b1, 1'b0, 3'b111, 24'hC3B2A1, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b000, 24'h0, 1'b0);
        n_checks++;
        assert (valid_out === 1'b1 && data_out === 24'hC3B2A1) else begin
            n_fail++;
            $error("[TB] FAIL simul_beat observed=%b/%h expected=1/c3b2a1", valid_out, data_out);
        end
        applyStimulus(1'b1, 1'b0, 3'b000, 24'h0, 1'b1);

        $display("[TB] streaming");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 3'b111, {8'(i + 32), 8'(i + 16), 8'(i)}, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 3'b000, 24'h0, 1'b1);

        $display("[TB] skewed arrival with backpressure");
        for (int c = 0; c <= 8; c++) begin
            logic [N-1:0] v;
            v = 3'b000;
            if (c == 0) v = 3'b001;
            if (c == 2) v = 3'b100;
            if (c == 5) v = 3'b010;
            if (c == 6) begin
`ifdef STREAM_JOIN_SKEW_EN
                n_checks++;
                assert (skew === 8'd5) else begin
                    n_fail++;
                    $error("[TB] FAIL skew_at_6 observed=%0d expected=5", skew);
                end
`endif
                n_checks++;
                assert (valid_out === 1'b1) else begin
                    n_fail++;
                    $error("[TB] FAIL skew_valid observed=%b expected=1", valid_out);
                end
            end
            applyStimulus(1'b1, 1'b0, v, 24'h33_22_11, (c == 8));
        end
        applyStimulus(1'b1, 1'b0, 3'b000, 24'h0, 1'b1);

        $display("[TB] drain and refill");
        applyStimulus(1'b1, 1'b0, 3'b111, 24'h5A4B3C, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b111, 24'h9F8E7D, 1'b1);
        n_checks++;
        assert (valid_out === 1'b1 && data_out === 24'h9F8E7D) else begin
            n_fail++;
            $error("[TB] FAIL refill observed=%b/%h expected=1/9f8e7d", valid_out, data_out);
        end
        applyStimulus(1'b1, 1'b0, 3'b000, 24'h0, 1'b1);

        $display("[TB] flush and reset with two of three slots full");
        applyStimulus(1'b1, 1'b0, 3'b011, 24'h00_77_66, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b111, 24'h11_22_33, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b000, 24'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b101, 24'h44_00_55, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'b111, 24'h11_22_33, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b000, 24'h0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 31) == 0,
                          3'($urandom_range(0, 7)), 24'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d beats modelled", n_beats);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
